mips_bus_sequencer: RTL and testbench
=====================================

MIPS_BUS_SEQUENCER -- requirements
Module: mips_bus_sequencer

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port pc, input, 32: fetch address from datapath.
REQ-004 SHALL have ports dec_mem_read, input, 1, and dec_mem_write, input, 1: load/store request from control unit.
REQ-005 SHALL have ports dec_addr, input, 32; dec_wdata, input, 32; dec_byteenable, input, 4: data access parameters.
REQ-006 SHALL have port halt_req, input, 1: datapath reports jump to address 0.
REQ-007 SHALL have ports bus_address, output, 32; bus_read, output, 1; bus_write, output, 1; bus_byteenable, output, 4; bus_writedata, output, 32.
REQ-008 SHALL have ports bus_waitrequest, input, 1, and bus_readdata, input, 32.
REQ-009 SHALL have ports instr, output, 32 (instruction register) and mem_rdata, output, 32 (load data register).
REQ-010 SHALL have ports ir_write, pc_update and reg_write_strobe, output, 1 each: one-cycle datapath strobes.
REQ-011 SHALL have port active, output, 1: high while executing, low once halted.

Function
REQ-012 SHALL implement states FETCH, DECODE, MEM, WB, HALTED.
REQ-013 FETCH SHALL drive bus_read=1, bus_address=pc, bus_byteenable=4'hF, and hold these until bus_waitrequest=0.
REQ-014 On FETCH with bus_waitrequest=0, SHALL latch bus_readdata into instr, pulse ir_write, and go to DECODE.
REQ-015 FETCH with pc[1:0]!=0 SHALL issue no bus access and go to HALTED.
REQ-016 DECODE SHALL last one cycle and go to MEM if dec_mem_read or dec_mem_write is set, else to WB.
REQ-017 MEM SHALL drive bus_address={dec_addr[31:2],2'b00}, bus_byteenable=dec_byteenable, and bus_writedata=dec_wdata for writes, holding all of these until bus_waitrequest=0.
REQ-018 If dec_mem_read and dec_mem_write are both set, SHALL perform the read only.
REQ-019 A MEM read completing SHALL latch bus_readdata into mem_rdata, and MEM SHALL then go to WB.
REQ-020 WB SHALL pulse reg_write_strobe and pc_update for one cycle, then go to FETCH, or to HALTED if halt_req=1 in WB.
REQ-021 HALTED SHALL be absorbing until reset, with active=0, bus_read=0, bus_write=0 and all strobes 0.
REQ-022 Latency with zero wait states: non-memory instruction 3 cycles, load/store 4 cycles; each wait cycle adds 1.
REQ-023 bus_read and bus_write SHALL never be asserted together and SHALL be 0 outside FETCH and MEM.

Reset
REQ-024 reset_n=0 SHALL immediately force bus_read=0, bus_write=0, bus_address=0, bus_byteenable=0, bus_writedata=0, instr=0, mem_rdata=0, all strobes 0 and active=0, regardless of clk.
REQ-025 Reset asserted mid-transaction SHALL abandon the access with no completion strobe.
REQ-026 On reset release, state SHALL be FETCH and active=1 from the first clk edge.

Configuration
REQ-027 Macro MIPS_SEQ_STALL_COUNT_EN defined: SHALL add port stall_cycles, output, 32, counting cycles with bus_read or bus_write asserted and bus_waitrequest=1.
REQ-028 With MIPS_SEQ_STALL_COUNT_EN defined: stall_cycles SHALL reset to 0, saturate at 32'hFFFFFFFF, and freeze in HALTED.
REQ-029 Macro undefined: port stall_cycles and the counter logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-030 Zero-wait ALU instruction, pc=0x0000_0040 -> bus_read=1 at 0x40 in cycle 1; ir_write in cycle 1; pc_update and reg_write_strobe in cycle 3.
REQ-031 Load, dec_addr=0x1003, bus_waitrequest=1 for 2 cycles -> bus_address=0x1000 held 3 cycles; mem_rdata=readdata; WB in cycle 6.
REQ-032 Store, dec_wdata=0xDEADBEEF, dec_byteenable=4'b0011 -> bus_write=1 for one cycle with those values; bus_read=0 throughout.
REQ-033 halt_req=1 in WB -> pc_update pulse, then active=0 and no further bus activity for 100 cycles.
REQ-034 reset_n low while bus_read=1 under waitrequest -> bus_read=0 within the same cycle, with no ir_write; fetch restarts after release.
REQ-035 With MIPS_SEQ_STALL_COUNT_EN, 5 fetch wait cycles plus 3 load wait cycles -> stall_cycles=8.

Source files
------------

// File: rtl/mips_bus_sequencer.sv
// -----------------------------------------------------------------------------
// mips_bus_sequencer
// Multi-cycle MIPS bus sequencer: walks each instruction through
// FETCH -> DECODE -> (MEM) -> WB and drives a single-master waitrequest bus.
// Optional feature: define MIPS_SEQ_STALL_COUNT_EN to add the stall_cycles
// output, which counts bus cycles stretched by bus_waitrequest.
// Bus request outputs, instr, mem_rdata, pc_update, reg_write_strobe and
// active come from registers. ir_write is decoded from the bus handshake so
// that it lines up with the cycle in which the fetch completes.
// -----------------------------------------------------------------------------
module mips_bus_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc,
    input  logic        dec_mem_read,
    input  logic        dec_mem_write,
    input  logic [31:0] dec_addr,
    input  logic [31:0] dec_wdata,
    input  logic [3:0]  dec_byteenable,
    input  logic        halt_req,
    output logic [31:0] bus_address,
    output logic        bus_read,
    output logic        bus_write,
    output logic [3:0]  bus_byteenable,
    output logic [31:0] bus_writedata,
    input  logic        bus_waitrequest,
    input  logic [31:0] bus_readdata,
    output logic [31:0] instr,
    output logic [31:0] mem_rdata,
    output logic        ir_write,
    output logic        pc_update,
    output logic        reg_write_strobe,
    output logic        active
`ifdef MIPS_SEQ_STALL_COUNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_MEM    = 3'd2;
    localparam logic [2:0] S_WB     = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    // Registered state and outputs
    logic [2:0]  r_state;
    logic        r_active;
    logic        r_bus_read;
    logic        r_bus_write;
    logic [31:0] r_bus_address;
    logic [3:0]  r_bus_byteenable;
    logic [31:0] r_bus_writedata;
    logic [31:0] r_instr;
    logic [31:0] r_mem_rdata;
    logic        r_pc_update;
    logic        r_reg_write_strobe;

    // Next-state values
    logic [2:0]  w_state_nx;
    logic        w_active_nx;
    logic        w_bus_read_nx;
    logic        w_bus_write_nx;
    logic [31:0] w_bus_address_nx;
    logic [3:0]  w_bus_byteenable_nx;
    logic [31:0] w_bus_writedata_nx;
    logic [31:0] w_instr_nx;
    logic [31:0] w_mem_rdata_nx;
    logic        w_pc_update_nx;
    logic        w_reg_write_strobe_nx;

    logic        w_pc_aligned;
    logic [31:0] w_mem_addr;
    logic        w_unused_addr_lsb;

    assign w_pc_aligned      = (pc[1:0] == 2'b00);
    assign w_mem_addr        = {dec_addr[31:2], 2'b00};
    // Data accesses are always word aligned; the low address bits are dropped.
    assign w_unused_addr_lsb = ^dec_addr[1:0];

    // Next-state and next-output decode for the instruction sequencer
    always_comb begin
        w_state_nx            = r_state;
        w_active_nx           = r_active;
        w_bus_read_nx         = r_bus_read;
        w_bus_write_nx        = r_bus_write;
        w_bus_address_nx      = r_bus_address;
        w_bus_byteenable_nx   = r_bus_byteenable;
        w_bus_writedata_nx    = r_bus_writedata;
        w_instr_nx            = r_instr;
        w_mem_rdata_nx        = r_mem_rdata;
        w_pc_update_nx        = 1'b0;
        w_reg_write_strobe_nx = 1'b0;

        case (r_state)
            S_FETCH: begin
                if (!r_active) begin
                    // First edge after reset: present the fetch of pc.
                    // A misaligned pc never reaches the bus.
                    w_active_nx         = 1'b1;
                    w_bus_read_nx       = w_pc_aligned;
                    w_bus_address_nx    = w_pc_aligned ? pc : 32'h0000_0000;
                    w_bus_byteenable_nx = w_pc_aligned ? 4'hF : 4'h0;
                    w_bus_writedata_nx  = 32'h0000_0000;
                end else if (!r_bus_read) begin
                    // Fetch was suppressed for a misaligned pc.
                    w_state_nx          = S_HALTED;
                    w_active_nx         = 1'b0;
                    w_bus_read_nx       = 1'b0;
                    w_bus_write_nx      = 1'b0;
                    w_bus_address_nx    = 32'h0000_0000;
                    w_bus_byteenable_nx = 4'h0;
                    w_bus_writedata_nx  = 32'h0000_0000;
                end else if (!bus_waitrequest) begin
                    w_state_nx          = S_DECODE;
                    w_instr_nx          = bus_readdata;
                    w_bus_read_nx       = 1'b0;
                    w_bus_write_nx      = 1'b0;
                    w_bus_address_nx    = 32'h0000_0000;
                    w_bus_byteenable_nx = 4'h0;
                    w_bus_writedata_nx  = 32'h0000_0000;
                end else begin
                    // Slave stalls: hold the request unchanged.
                    w_state_nx = S_FETCH;
                end
            end
            S_DECODE: begin
                if (dec_mem_read) begin
                    // A read wins when read and write are both requested.
                    w_state_nx          = S_MEM;
                    w_bus_read_nx       = 1'b1;
                    w_bus_write_nx      = 1'b0;
                    w_bus_address_nx    = w_mem_addr;
                    w_bus_byteenable_nx = dec_byteenable;
                    w_bus_writedata_nx  = 32'h0000_0000;
                end else if (dec_mem_write) begin
                    w_state_nx          = S_MEM;
                    w_bus_read_nx       = 1'b0;
                    w_bus_write_nx      = 1'b1;
                    w_bus_address_nx    = w_mem_addr;
                    w_bus_byteenable_nx = dec_byteenable;
                    w_bus_writedata_nx  = dec_wdata;
                end else begin
                    w_state_nx            = S_WB;
                    w_pc_update_nx        = 1'b1;
                    w_reg_write_strobe_nx = 1'b1;
                end
            end
            S_MEM: begin
                if (!bus_waitrequest) begin
                    if (r_bus_read) begin
                        w_mem_rdata_nx = bus_readdata;
                    end else begin
                        w_mem_rdata_nx = r_mem_rdata;
                    end
                    w_state_nx            = S_WB;
                    w_pc_update_nx        = 1'b1;
                    w_reg_write_strobe_nx = 1'b1;
                    w_bus_read_nx         = 1'b0;
                    w_bus_write_nx        = 1'b0;
                    w_bus_address_nx      = 32'h0000_0000;
                    w_bus_byteenable_nx   = 4'h0;
                    w_bus_writedata_nx    = 32'h0000_0000;
                end else begin
                    w_state_nx = S_MEM;
                end
            end
            S_WB: begin
                if (halt_req) begin
                    w_state_nx  = S_HALTED;
                    w_active_nx = 1'b0;
                end else begin
                    w_state_nx          = S_FETCH;
                    w_bus_read_nx       = w_pc_aligned;
                    w_bus_write_nx      = 1'b0;
                    w_bus_address_nx    = w_pc_aligned ? pc : 32'h0000_0000;
                    w_bus_byteenable_nx = w_pc_aligned ? 4'hF : 4'h0;
                    w_bus_writedata_nx  = 32'h0000_0000;
                end
            end
            S_HALTED: begin
                // Absorbing until reset: keep the bus idle.
                w_state_nx          = S_HALTED;
                w_active_nx         = 1'b0;
                w_bus_read_nx       = 1'b0;
                w_bus_write_nx      = 1'b0;
                w_bus_address_nx    = 32'h0000_0000;
                w_bus_byteenable_nx = 4'h0;
                w_bus_writedata_nx  = 32'h0000_0000;
            end
            default: begin
                // Corrupted state encoding: park safely.
                w_state_nx          = S_HALTED;
                w_active_nx         = 1'b0;
                w_bus_read_nx       = 1'b0;
                w_bus_write_nx      = 1'b0;
                w_bus_address_nx    = 32'h0000_0000;
                w_bus_byteenable_nx = 4'h0;
                w_bus_writedata_nx  = 32'h0000_0000;
            end
        endcase
    end

    // State and output registers; reset clears everything asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state            <= S_FETCH;
            r_active           <= 1'b0;
            r_bus_read         <= 1'b0;
            r_bus_write        <= 1'b0;
            r_bus_address      <= 32'h0000_0000;
            r_bus_byteenable   <= 4'h0;
            r_bus_writedata    <= 32'h0000_0000;
            r_instr            <= 32'h0000_0000;
            r_mem_rdata        <= 32'h0000_0000;
            r_pc_update        <= 1'b0;
            r_reg_write_strobe <= 1'b0;
        end else begin
            r_state            <= w_state_nx;
            r_active           <= w_active_nx;
            r_bus_read         <= w_bus_read_nx;
            r_bus_write        <= w_bus_write_nx;
            r_bus_address      <= w_bus_address_nx;
            r_bus_byteenable   <= w_bus_byteenable_nx;
            r_bus_writedata    <= w_bus_writedata_nx;
            r_instr            <= w_instr_nx;
            r_mem_rdata        <= w_mem_rdata_nx;
            r_pc_update        <= w_pc_update_nx;
            r_reg_write_strobe <= w_reg_write_strobe_nx;
        end
    end

    assign bus_read         = r_bus_read;
    assign bus_write        = r_bus_write;
    assign bus_address      = r_bus_address;
    assign bus_byteenable   = r_bus_byteenable;
    assign bus_writedata    = r_bus_writedata;
    assign instr            = r_instr;
    assign mem_rdata        = r_mem_rdata;
    assign pc_update        = r_pc_update;
    assign reg_write_strobe = r_reg_write_strobe;
    assign active           = r_active;
    // The fetch completes in the cycle the slave drops waitrequest.
    assign ir_write         = (r_state == S_FETCH) && r_bus_read && !bus_waitrequest;

`ifdef MIPS_SEQ_STALL_COUNT_EN
    logic [31:0] r_stall_cycles;
    logic        w_stall_s;

    function automatic logic [31:0] sat_inc(input logic [31:0] val);
        if (val == 32'hFFFF_FFFF) begin
            sat_inc = val;
        end else begin
            sat_inc = val + 32'd1;
        end
    endfunction

    assign w_stall_s = (r_state != S_HALTED) && (r_bus_read || r_bus_write) && bus_waitrequest;

    // Saturating count of bus cycles stretched by waitrequest
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= 32'h0000_0000;
        end else if (w_stall_s) begin
            r_stall_cycles <= sat_inc(r_stall_cycles);
        end else begin
            r_stall_cycles <= r_stall_cycles;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_mips_bus_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mips_bus_sequencer
// Directed instruction stream with a scoreboard: the stimulus pushes expected
// bus/writeback events (with expected cycle numbers) into a queue, and a
// monitor pops and compares them whenever the DUT presents an event.
// -----------------------------------------------------------------------------
module tb_mips_bus_sequencer;

    localparam int K_FETCH = 0;
    localparam int K_RD    = 1;
    localparam int K_WR    = 2;
    localparam int K_WB    = 3;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    logic        clk;
    logic        reset_n;
    logic [31:0] pc;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic [31:0] dec_addr;
    logic [31:0] dec_wdata;
    logic [3:0]  dec_byteenable;
    logic        halt_req;
    logic [31:0] bus_address;
    logic        bus_read;
    logic        bus_write;
    logic [3:0]  bus_byteenable;
    logic [31:0] bus_writedata;
    logic        bus_waitrequest;
    logic [31:0] bus_readdata;
    logic [31:0] instr;
    logic [31:0] mem_rdata;
    logic        ir_write;
    logic        pc_update;
    logic        reg_write_strobe;
    logic        active;
`ifdef MIPS_SEQ_STALL_COUNT_EN
    logic [31:0] stall_cycles;
`endif

    int          total;
    int          bad;
    int          cyc;
    int          next_start;
    logic [31:0] exp_mrd;
    ev_t         sb[$];
    int          wait_q[$];
    int          wait_left;
    logic        in_acc;

    mips_bus_sequencer dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .pc               (pc),
        .dec_mem_read     (dec_mem_read),
        .dec_mem_write    (dec_mem_write),
        .dec_addr         (dec_addr),
        .dec_wdata        (dec_wdata),
        .dec_byteenable   (dec_byteenable),
        .halt_req         (halt_req),
        .bus_address      (bus_address),
        .bus_read         (bus_read),
        .bus_write        (bus_write),
        .bus_byteenable   (bus_byteenable),
        .bus_writedata    (bus_writedata),
        .bus_waitrequest  (bus_waitrequest),
        .bus_readdata     (bus_readdata),
        .instr            (instr),
        .mem_rdata        (mem_rdata),
        .ir_write         (ir_write),
        .pc_update        (pc_update),
        .reg_write_strobe (reg_write_strobe)
        ,
        .active           (active)
`ifdef MIPS_SEQ_STALL_COUNT_EN
        ,
        .stall_cycles     (stall_cycles)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        mem_word = {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h5A5A};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Bus slave: per-access wait-state count taken from wait_q
    always @(posedge clk) begin
        #1;
        if (reset_n !== 1'b1) begin
            in_acc          = 1'b0;
            bus_waitrequest = 1'b0;
        end else if (bus_read || bus_write) begin
            if (!in_acc) begin
                in_acc    = 1'b1;
                wait_left = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
            end
            if (wait_left > 0) begin
                bus_waitrequest = 1'b1;
                wait_left--;
            end else begin
                bus_waitrequest = 1'b0;
                in_acc          = 1'b0;
            end
            bus_readdata = mem_word(bus_address);
        end else begin
            bus_waitrequest = 1'b0;
            in_acc          = 1'b0;
        end
    end

    // Monitor: classify the DUT event of this cycle and compare against the scoreboard
    always @(negedge clk) begin
        ev_t o;
        ev_t e;
        logic has;
        if (reset_n === 1'b1) begin
            if (bus_read || bus_write) chk("rw_excl", {31'b0, bus_read & bus_write}, 32'd0);
            has = 1'b1;
            o.cyc  = cyc;
            o.data = 32'h0;
            if (ir_write) begin
                o.kind = K_FETCH; o.addr = bus_address; o.be = bus_byteenable;
            end else if (bus_read && !bus_waitrequest) begin
                o.kind = K_RD; o.addr = bus_address; o.be = bus_byteenable;
            end else if (bus_write && !bus_waitrequest) begin
                o.kind = K_WR; o.addr = bus_address; o.be = bus_byteenable; o.data = bus_writedata;
            end else if (pc_update || reg_write_strobe) begin
                o.kind = K_WB; o.addr = instr; o.be = {2'b00, reg_write_strobe, pc_update}; o.data = mem_rdata;
            end else begin
                has = 1'b0;
            end
            if (has) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: actual kind=%0d addr=%h cycle=%0d required none", o.kind, o.addr, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("ev_kind", o.kind, e.kind);
                    chk("ev_cycle", o.cyc, e.cyc);
                    chk("ev_addr_or_instr", o.addr, e.addr);
                    chk("ev_be_or_strobes", {28'b0, o.be}, {28'b0, e.be});
                    chk("ev_wdata_or_mrdata", o.data, e.data);
                end
            end
        end
    end

    // Issue one instruction: push expectations, then wait through its writeback
    task automatic run_instr(input logic [31:0] a_pc, input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                             input int fw, input int mw, input logic hlt);
        int  s;
        int  wbc;
        ev_t e;
        pc             = a_pc;
        dec_mem_read   = rd;
        dec_mem_write  = wr;
        dec_addr       = addr;
        dec_wdata      = wdata;
        dec_byteenable = be;
        s              = next_start;
        wait_q.push_back(fw);
        e = '{K_FETCH, a_pc, 4'hF, 32'h0, s + fw};
        sb.push_back(e);
        wbc = s + fw + 2;
        if (rd || wr) begin
            wait_q.push_back(mw);
            if (rd) begin
                e = '{K_RD, {addr[31:2], 2'b00}, be, 32'h0, s + fw + 2 + mw};
                exp_mrd = mem_word({addr[31:2], 2'b00});
            end else begin
                e = '{K_WR, {addr[31:2], 2'b00}, be, wdata, s + fw + 2 + mw};
            end
            sb.push_back(e);
            wbc = s + fw + 3 + mw;
        end
        e = '{K_WB, mem_word(a_pc), 4'b0011, exp_mrd, wbc};
        sb.push_back(e);
        while (cyc < s) @(negedge clk);
        chk("active_running", {31'b0, active}, 32'd1);
        halt_req = hlt;
        while (cyc < wbc) @(negedge clk);
        next_start = wbc + 1;
    endtask

    task automatic release_reset();
        reset_n    = 1'b1;
        next_start = cyc + 1;
        exp_mrd    = 32'h0;
    endtask

    initial begin
        int quiet;
        total = 0; bad = 0; cyc = 0;
        wait_left = 0; in_acc = 1'b0;
        bus_waitrequest = 1'b0; bus_readdata = 32'h0;
        pc = 32'h0; dec_mem_read = 1'b0; dec_mem_write = 1'b0;
        dec_addr = 32'h0; dec_wdata = 32'h0; dec_byteenable = 4'h0; halt_req = 1'b0;
        reset_n = 1'b0;

        // Reset state while the clock runs
        repeat (3) @(negedge clk);
        chk("reset_outputs", {31'b0, |{bus_address, bus_read, bus_write, bus_byteenable, bus_writedata,
                               instr, mem_rdata, ir_write, pc_update, reg_write_strobe, active}}, 32'd0);
        release_reset();

        // Instruction stream
        run_instr(32'h0000_0040, 1'b0, 1'b0, 32'h0,         32'h0,         4'h0,    0, 0, 1'b0);
        run_instr(32'h0000_0044, 1'b1, 1'b0, 32'h0000_1003, 32'h0,         4'hF,    0, 2, 1'b0);
        run_instr(32'h0000_0048, 1'b0, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'b0011, 0, 0, 1'b0);
        run_instr(32'h0000_004C, 1'b1, 1'b1, 32'h0000_3006, 32'h1234_5678, 4'b1111, 0, 0, 1'b0);
        run_instr(32'h0000_0050, 1'b0, 1'b0, 32'h0,         32'h0,         4'h0,    3, 0, 1'b0);
        run_instr(32'h0000_0054, 1'b0, 1'b1, 32'h0000_2104, 32'hCAFE_F00D, 4'b1100, 1, 2, 1'b0);
        run_instr(32'h0000_0058, 1'b0, 1'b0, 32'h0,         32'h0,         4'h0,    0, 0, 1'b1);

        // Halted: inactive and quiet for 100 cycles
        @(negedge clk);
        chk("halt_active", {31'b0, active}, 32'd0);
        quiet = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus_read || bus_write || ir_write || pc_update || reg_write_strobe || active) quiet++;
        end
        chk("halt_quiet", quiet, 0);

        // Reset during a stalled fetch
        reset_n = 1'b0;
        @(negedge clk);
        pc = 32'h0000_0080; dec_mem_read = 1'b0; dec_mem_write = 1'b0; halt_req = 1'b0;
        wait_q.push_back(5);
        release_reset();
        @(negedge clk);
        chk("fetch_stalled", {30'b0, bus_read, bus_waitrequest}, 32'd3);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_abort_read", {31'b0, bus_read}, 32'd0);
        chk("rst_no_ir_write", {31'b0, ir_write}, 32'd0);
        chk("rst_outputs_mid", {31'b0, |{bus_address, bus_read, bus_write, bus_byteenable, bus_writedata,
                                 instr, mem_rdata, ir_write, pc_update, reg_write_strobe, active}}, 32'd0);
        repeat (2) @(negedge clk);
        release_reset();
        run_instr(32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 0, 1'b1);
        @(negedge clk);
        chk("halt_active_b", {31'b0, active}, 32'd0);

        // Misaligned pc: no bus access, straight to halt
        reset_n = 1'b0;
        @(negedge clk);
        pc = 32'h0000_0042;
        release_reset();
        @(negedge clk);
        chk("misaligned_no_read", {31'b0, bus_read}, 32'd0);
        @(negedge clk);
        chk("misaligned_halted", {31'b0, active}, 32'd0);
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus_read || bus_write || ir_write || pc_update || active) quiet++;
        end
        chk("misaligned_quiet", quiet, 0);

`ifdef MIPS_SEQ_STALL_COUNT_EN
        // Stall counter: 5 fetch wait cycles plus 3 load wait cycles
        reset_n = 1'b0;
        @(negedge clk);
        release_reset();
        run_instr(32'h0000_0200, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'hF, 5, 3, 1'b1);
        @(negedge clk);
        chk("stall_cycles", stall_cycles, 32'd8);
        repeat (10) @(negedge clk);
        chk("stall_frozen", stall_cycles, 32'd8);
`endif

        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
